// File: rtl/multi_edge_detector_pkg.sv
// ---------------------------------------------------------------------------
// multi_edge_detector_pkg : mode encodings, parameter defaults, event decode
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multi_edge_detector_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_CNT_W       = 8;

  function automatic logic mode_event(input logic [1:0] mode,
                                      input logic       rise,
                                      input logic       fall);
    return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
           (fall && (mode == MODE_FALL || mode == MODE_BOTH));
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_edge_detector_edge_chan.sv
// ---------------------------------------------------------------------------
// edge_chan : one channel of sync, debounce, edge pulse, pending and counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_chan
  import multi_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_level,
  input  logic [1:0]       i_mode,
  input  logic             i_clr_pend,
  input  logic             i_clr_cnt,
  output logic             o_p_edge,
  output logic             o_n_edge,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_evt_cnt
);

  localparam int              DCW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   w_f;
  logic                   r_fd;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_evt;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (DEB_CYCLES == 0) begin : g_nodeb
      assign w_f = w_s;
    end else begin : g_deb
      logic           r_f;
      logic [DCW-1:0] r_dcnt;

      // Any cycle where the sample agrees with the filtered state restarts the count
      always_ff @(posedge clk) begin
        if (reset) begin
          r_f    <= 1'b0;
          r_dcnt <= '0;
        end else if (w_s == r_f) begin
          r_dcnt <= '0;
        end else if (r_dcnt == DCW'(DEB_CYCLES - 1)) begin
          r_f    <= w_s;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end

      assign w_f = r_f;
    end
  endgenerate

  assign w_rise = w_f & ~r_fd;
  assign w_fall = ~w_f & r_fd;
  assign w_evt  = mode_event(i_mode, w_rise, w_fall);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fd      <= 1'b0;
      o_p_edge  <= 1'b0;
      o_n_edge  <= 1'b0;
      o_pending <= 1'b0;
      o_evt_cnt <= '0;
    end else begin
      r_fd     <= w_f;
      o_p_edge <= w_rise;
      o_n_edge <= w_fall;

      if (w_evt)           o_pending <= 1'b1;
      else if (i_clr_pend) o_pending <= 1'b0;

      // A clear coinciding with an event counts that event
      if (i_clr_cnt)
        o_evt_cnt <= w_evt ? CNT_W'(1) : '0;
      else if (w_evt && o_evt_cnt != CNT_MAX)
        o_evt_cnt <= o_evt_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_edge_detector.sv
// ---------------------------------------------------------------------------
// multi_edge_detector : N_CH debounced edge detectors with pending/irq/counters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       level,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr_pend,
  input  logic [N_CH-1:0]       clr_cnt,
  output logic [N_CH-1:0]       p_edge,
  output logic [N_CH-1:0]       n_edge,
  output logic [N_CH-1:0]       any_edge,
  output logic [N_CH-1:0]       pending,
  output logic                  irq,
  output logic [N_CH*CNT_W-1:0] evt_cnt
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      edge_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .i_level    (level[i]),
        .i_mode     (mode[2*i +: 2]),
        .i_clr_pend (clr_pend[i]),
        .i_clr_cnt  (clr_cnt[i]),
        .o_p_edge   (p_edge[i]),
        .o_n_edge   (n_edge[i]),
        .o_pending  (pending[i]),
        .o_evt_cnt  (evt_cnt[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign any_edge = p_edge | n_edge;
  assign irq      = |pending;

endmodule

`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
// ---------------------------------------------------------------------------
// tb_multi_edge_detector : directed scenarios plus randomized model comparison
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multi_edge_detector;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   level;
  logic [2*N-1:0] mode;
  logic [N-1:0]   clr_pend;
  logic [N-1:0]   clr_cnt;

  logic [N-1:0]   p_edge, n_edge, any_edge, pending;
  logic           irq;
  logic [N*8-1:0] evt_cnt;
  logic [N-1:0]   p2, n2, any2, pend2;
  logic           irq2;
  logic [N*2-1:0] evt_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_edge_detector dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode),
    .clr_pend(clr_pend), .clr_cnt(clr_cnt),
    .p_edge(p_edge), .n_edge(n_edge), .any_edge(any_edge),
    .pending(pending), .irq(irq), .evt_cnt(evt_cnt)
  );

  multi_edge_detector #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .level(level), .mode(mode),
    .clr_pend(clr_pend), .clr_cnt(clr_cnt),
    .p_edge(p2), .n_edge(n2), .any_edge(any2),
    .pending(pend2), .irq(irq2), .evt_cnt(evt_cnt2)
  );

  // Reference model: filtered level changes once the delayed sample has
  // disagreed with it for DEB consecutive cycles; pulses lag that by one.
  logic [N-1:0] lvl_q[$];
  logic [N-1:0] m_f, m_fd, m_p, m_n, m_pend;
  int           m_run[N];
  int           m_cnt8[N];
  int           m_cnt2[N];
  logic [N-1:0] m_tmp;
  logic         m_s, m_np, m_nn, m_evt;
  logic [1:0]   m_md;

  always @(posedge clk) begin
    if (reset) begin
      m_f = '0; m_fd = '0; m_p = '0; m_n = '0; m_pend = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_cnt8[c] = 0; m_cnt2[c] = 0;
      end
      lvl_q.delete();
      for (int k = 0; k < SYNC; k++) lvl_q.push_back('0);
    end else begin
      if (lvl_q.size() >= SYNC) m_tmp = lvl_q[lvl_q.size() - SYNC];
      else                      m_tmp = '0;
      for (int c = 0; c < N; c++) begin
        m_s  = m_tmp[c];
        m_np = m_f[c] & ~m_fd[c];
        m_nn = ~m_f[c] & m_fd[c];
        m_fd[c] = m_f[c];
        if (m_s != m_f[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_f[c]   = m_s;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_md  = mode[2*c +: 2];
        m_evt = (m_np && m_md[0]) || (m_nn && m_md[1]);
        if (m_evt)            m_pend[c] = 1'b1;
        else if (clr_pend[c]) m_pend[c] = 1'b0;
        if (clr_cnt[c]) begin
          m_cnt8[c] = m_evt ? 1 : 0;
          m_cnt2[c] = m_evt ? 1 : 0;
        end else if (m_evt) begin
          if (m_cnt8[c] < 255) m_cnt8[c]++;
          if (m_cnt2[c] < 3)   m_cnt2[c]++;
        end
        m_p[c] = m_np;
        m_n[c] = m_nn;
      end
      lvl_q.push_back(level);
      if (lvl_q.size() > SYNC + 2) void'(lvl_q.pop_front());
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_edge, n_edge, any_edge, pending, irq} !== '0) begin
      errors++;
      $display("FAIL reset_flags: got %h required 0", {p_edge, n_edge, any_edge, pending, irq});
    end
    checks++;
    if (evt_cnt !== '0 || evt_cnt2 !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %h/%h required 0", evt_cnt, evt_cnt2);
    end
    reset = 1'b0;
  endtask

  task automatic test_rise_latency();
    mode[1:0] = 2'b01;
    level[0]  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (p_edge[0] !== (k == 7) || n_edge[0] !== 1'b0) begin
        errors++;
        $display("FAIL rise_pulse cycle %0d: got p=%b n=%b required p=%b n=0",
                 k, p_edge[0], n_edge[0], (k == 7));
      end
    end
    checks++;
    if (pending[0] !== 1'b1 || irq !== 1'b1 || evt_cnt[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL rise_result: got pend=%b irq=%b cnt=%0d required 1 1 1",
               pending[0], irq, evt_cnt[7:0]);
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    mode[3:2] = 2'b11;
    level[1]  = 1'b1;
    repeat (3) @(negedge clk);
    level[1] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | p_edge[1] | n_edge[1];
    end
    checks++;
    if (seen !== 1'b0 || evt_cnt[15:8] !== 8'd0) begin
      errors++;
      $display("FAIL glitch: got edge_seen=%b cnt=%0d required 0 0", seen, evt_cnt[15:8]);
    end
  endtask

  task automatic test_fall_mode();
    int pc = 0;
    int nc = 0;
    mode[5:4] = 2'b10;
    level[2]  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      pc += int'(p_edge[2]); nc += int'(n_edge[2]);
    end
    level[2] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      pc += int'(p_edge[2]); nc += int'(n_edge[2]);
    end
    checks++;
    if (pc != 1 || nc != 1) begin
      errors++;
      $display("FAIL fall_pulses: got p=%0d n=%0d required 1 1", pc, nc);
    end
    checks++;
    if (evt_cnt[23:16] !== 8'd1 || pending[2] !== 1'b1) begin
      errors++;
      $display("FAIL fall_count: got cnt=%0d pend=%b required 1 1", evt_cnt[23:16], pending[2]);
    end
  endtask

  task automatic test_saturate();
    clr_cnt[3] = 1'b1;
    @(negedge clk);
    clr_cnt[3] = 1'b0;
    mode[7:6]  = 2'b11;
    repeat (5) begin
      level[3] = ~level[3];
      repeat (10) @(negedge clk);
    end
    checks++;
    if (evt_cnt2[7:6] !== 2'd3 || evt_cnt[31:24] !== 8'd5) begin
      errors++;
      $display("FAIL saturate: got c2=%0d c8=%0d required 3 5", evt_cnt2[7:6], evt_cnt[31:24]);
    end
    level[3] = ~level[3];
    repeat (6) @(negedge clk);
    clr_cnt[3] = 1'b1;
    @(negedge clk);
    clr_cnt[3] = 1'b0;
    checks++;
    if (n_edge[3] !== 1'b1 || evt_cnt2[7:6] !== 2'd1 || evt_cnt[31:24] !== 8'd1) begin
      errors++;
      $display("FAIL clr_cnt_evt: got n=%b c2=%0d c8=%0d required 1 1 1",
               n_edge[3], evt_cnt2[7:6], evt_cnt[31:24]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clr_pend();
    clr_pend = '1;
    @(negedge clk);
    clr_pend = '0;
    checks++;
    if (pending !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_all: got pend=%b irq=%b required 0000 0", pending, irq);
    end
    mode[1:0] = 2'b11;
    level[0]  = 1'b0;
    repeat (6) @(negedge clk);
    clr_pend[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (n_edge[0] !== 1'b1 || pending[0] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: got n=%b pend=%b irq=%b required 1 1 1", n_edge[0], pending[0], irq);
    end
    @(negedge clk);
    clr_pend[0] = 1'b0;
    checks++;
    if (pending[0] !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: got pend=%b irq=%b required 0 0", pending[0], irq);
    end
  endtask

  task automatic test_reset_mid();
    level[0] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({p_edge, n_edge, any_edge, pending, irq, evt_cnt, evt_cnt2} !== '0) begin
        errors++;
        $display("FAIL in_reset %0d: got p=%b n=%b pend=%b irq=%b cnt=%h required all 0",
                 k, p_edge, n_edge, pending, irq, evt_cnt);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (p_edge[0] !== (k == 7)) begin
        errors++;
        $display("FAIL post_reset_pulse cycle %0d: got %b required %b", k, p_edge[0], (k == 7));
      end
    end
  endtask

  task automatic test_random();
    logic [N*8-1:0] exp8;
    logic [N*2-1:0] exp2;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        exp8[c*8 +: 8] = 8'(m_cnt8[c]);
        exp2[c*2 +: 2] = 2'(m_cnt2[c]);
      end
      checks++;
      if ({p_edge, n_edge, any_edge} !== {m_p, m_n, m_p | m_n} ||
          {p2, n2, any2} !== {m_p, m_n, m_p | m_n}) begin
        errors++;
        $display("FAIL rand_edges t=%0d: got p=%b n=%b a=%b required p=%b n=%b",
                 t, p_edge, n_edge, any_edge, m_p, m_n);
      end
      checks++;
      if (pending !== m_pend || irq !== (|m_pend) || pend2 !== m_pend || irq2 !== (|m_pend)) begin
        errors++;
        $display("FAIL rand_pending t=%0d: got %b irq=%b required %b", t, pending, irq, m_pend);
      end
      checks++;
      if (evt_cnt !== exp8 || evt_cnt2 !== exp2) begin
        errors++;
        $display("FAIL rand_count t=%0d: got %h/%h required %h/%h", t, evt_cnt, evt_cnt2, exp8, exp2);
      end
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0)  level[c] = ~level[c];
        if ($urandom_range(0, 63) == 0) mode[2*c +: 2] = 2'($urandom);
        clr_pend[c] = ($urandom_range(0, 15) == 0);
        clr_cnt[c]  = ($urandom_range(0, 31) == 0);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    level    = '0;
    mode     = '0;
    clr_pend = '0;
    clr_cnt  = '0;
    test_reset();
    test_rise_latency();
    test_glitch();
    test_fall_mode();
    test_saturate();
    test_clr_pend();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (>=2).
REQ-003 Parameter DEB_CYCLES, default 4, consecutive stable cycles needed to accept a level change (0 = no debounce).
REQ-004 Parameter CNT_W, default 8, width of each per-channel event counter.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 level  in  N_CH  asynchronous raw input levels, bit i = channel i.
REQ-008 mode  in  2*N_CH  per-channel event select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 clr_pend  in  N_CH  per-channel pending-flag clear, level-sampled each cycle.
REQ-010 clr_cnt  in  N_CH  per-channel counter clear, level-sampled each cycle.
REQ-011 p_edge  out  N_CH  one-cycle pulse on filtered 0->1 transition.
REQ-012 n_edge  out  N_CH  one-cycle pulse on filtered 1->0 transition.
REQ-013 any_edge  out  N_CH  p_edge OR n_edge, same cycle.
REQ-014 pending  out  N_CH  sticky flag, set by a mode-selected event.
REQ-015 irq  out  1  OR-reduction of pending, registered with pending (no extra delay).
REQ-016 evt_cnt  out  N_CH*CNT_W  per-channel saturating count of mode-selected events, channel i at [i*CNT_W +: CNT_W].

Function
REQ-017 Each channel SHALL pass level through SYNC_STAGES flops; the last stage output is the sampled value s.
REQ-018 Each channel SHALL hold a filtered state f and a debounce counter; counter clears whenever s == f and increments while s != f.
REQ-019 f SHALL take the value of s on the cycle the counter reaches DEB_CYCLES-1 with s still != f; with DEB_CYCLES=0, f follows s directly each cycle.
REQ-020 p_edge/n_edge SHALL be registered, asserted the cycle after f changes, high exactly one cycle per change.
REQ-021 Latency from first clock edge sampling a new stable level to the edge pulse SHALL be SYNC_STAGES+DEB_CYCLES+1 cycles (7 at defaults).
REQ-022 A change of s lasting fewer than DEB_CYCLES cycles SHALL produce no edge and SHALL restart the debounce count.
REQ-023 A mode-selected event SHALL be asserted on the same edge as p_edge/n_edge per mode; mode 00 suppresses pending and counting but not p_edge/n_edge.
REQ-024 pending[i] SHALL set on an event; clear on clr_pend[i]; simultaneous set and clear -> pending stays 1 (set wins).
REQ-025 evt_cnt[i] SHALL increment by 1 per event and saturate at 2^CNT_W-1 without wrap.
REQ-026 Simultaneous clr_cnt[i] and event SHALL load count 1.
REQ-027 Mode changes SHALL take effect for events on the next cycle; no retroactive event is generated.
REQ-028 Channels SHALL be fully independent; simultaneous events on all channels are all captured.

Reset
REQ-029 On reset: sync flops, f, debounce counters, p_edge, n_edge, any_edge, pending, irq, evt_cnt all 0.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; a level held high through reset release yields a p_edge after REQ-021 latency.

Structure
REQ-031 Shared package SHALL hold mode encoding constants (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and parameter defaults.
REQ-032 One sub-module edge_chan (sync, debounce, edge, pending, counter for one channel) SHALL be instantiated N_CH times via generate; irq OR-reduction in the top.

Verification
REQ-033 Defaults, ch0 mode 01, level[0] 0->1 held -> p_edge[0] pulse 1 cycle at cycle 7, pending[0]=1, irq=1, evt_cnt[0]=1.
REQ-034 level[1] high for 3 cycles then low, DEB_CYCLES=4 -> no p_edge[1]/n_edge[1], evt_cnt[1]=0.
REQ-035 ch2 mode 10, toggle 0->1->0 with 10-cycle holds -> p_edge[2] and n_edge[2] each pulse once; evt_cnt[2]=1.
REQ-036 CNT_W=2, ch3 mode 11, 5 clean toggles -> evt_cnt[3] stops at 3; clr_cnt[3] coincident with next event -> evt_cnt[3]=1.
REQ-037 clr_pend[0] asserted same cycle as new ch0 event -> pending[0] remains 1; clr_pend alone next cycle -> pending[0]=0, irq=0.
REQ-038 Reset asserted 2 cycles into a debounce count, level held high -> all outputs 0 during reset; p_edge 7 cycles after release.
